// File: rtl/stream_demux.sv
// Registered valid/ready demux: routes one input stream to one of 2**CTRL
// output channels, or to all of them, through a one-entry register per channel.
module stream_demux #(
   parameter int CTRL       = 2,
   parameter int DATA_WIDTH = 1,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic [CTRL-1:0]       in_sel,
   input  logic                  in_bcast,
   output logic                  out_valid [2**CTRL],
   input  logic                  out_ready [2**CTRL],
   output logic [DATA_WIDTH-1:0] out_data  [2**CTRL],
   output logic                  busy,
   output logic [CNT_WIDTH-1:0]  xfer_cnt
);

   localparam int N = 2**CTRL;

   logic [N-1:0]          valid_q;
   logic [N-1:0]          valid_d;
   logic [DATA_WIDTH-1:0] data_q [N];
   logic [DATA_WIDTH-1:0] data_d [N];
   logic [CNT_WIDTH-1:0]  cnt_q;
   logic [CNT_WIDTH-1:0]  cnt_d;
   logic [N-1:0]          can_acc;
   logic                  fire;

   always_comb begin
      can_acc = '0;
      for (int i = 0; i < N; i++) begin
         can_acc[i] = !valid_q[i] || out_ready[i];
      end
   end

   // Broadcast needs every channel free so it is never split.
   assign in_ready = !reset &&
                     (in_bcast ? (&can_acc) : can_acc[in_sel]);
   assign fire     = in_valid && in_ready;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      cnt_d   = cnt_q;
      for (int i = 0; i < N; i++) begin
         if (fire && (in_bcast || (in_sel == CTRL'(i)))) begin
            valid_d[i] = 1'b1;
            data_d[i]  = in_data;
         end else if (out_ready[i]) begin
            valid_d[i] = 1'b0;
         end
      end
      if (fire) begin
         cnt_d = cnt_q + CNT_WIDTH'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= '0;
         cnt_q   <= '0;
         for (int i = 0; i < N; i++) begin
            data_q[i] <= '0;
         end
      end else begin
         valid_q <= valid_d;
         cnt_q   <= cnt_d;
         for (int i = 0; i < N; i++) begin
            data_q[i] <= data_d[i];
         end
      end
   end

   // Drained channels keep their old payload internally; mask it here.
   always_comb begin
      for (int i = 0; i < N; i++) begin
         out_valid[i] = valid_q[i];
         out_data[i]  = valid_q[i] ? data_q[i] : '0;
      end
   end

   assign busy     = |valid_q;
   assign xfer_cnt = cnt_q;

endmodule

// File: tb/tb_stream_demux.sv
// Bench for stream_demux: directed scenarios plus randomized traffic
// checked against a per-channel occupancy model.
module tb_stream_demux;

   logic       clk = 1'b0;
   logic       reset;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
   logic [1:0] in_sel;
   logic       in_bcast;
   logic       out_valid [4];
   logic       out_ready [4];
   logic [7:0] out_data  [4];
   logic       busy;
   logic [15:0] xfer_cnt;

   logic       w_in_ready;
   logic       w_out_valid [4];
   logic [7:0] w_out_data  [4];
   logic       w_busy;
   logic [3:0] w_xfer;

   int n_checks = 0;
   int n_errors = 0;

   bit          mv [4];
   logic [7:0]  md [4];
   int unsigned mcnt;

   stream_demux #(.CTRL(2), .DATA_WIDTH(8), .CNT_WIDTH(16)) u_dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_sel(in_sel), .in_bcast(in_bcast),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .busy(busy), .xfer_cnt(xfer_cnt)
   );

   stream_demux #(.CTRL(2), .DATA_WIDTH(8), .CNT_WIDTH(4)) u_wrap (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(w_in_ready),
      .in_data(in_data), .in_sel(in_sel), .in_bcast(in_bcast),
      .out_valid(w_out_valid), .out_ready(out_ready),
      .out_data(w_out_data), .busy(w_busy), .xfer_cnt(w_xfer)
   );

   always #5 clk = ~clk;

   function automatic logic [3:0] ov();
      logic [3:0] v;
      for (int i = 0; i < 4; i++) v[i] = out_valid[i];
      return v;
   endfunction

   // A slot accepts if empty or being emptied; broadcast needs all slots.
   function automatic bit m_ready();
      bit ok;
      if (reset) return 1'b0;
      if (!in_bcast) return !mv[in_sel] || out_ready[in_sel];
      ok = 1'b1;
      for (int i = 0; i < 4; i++) ok &= !mv[i] || out_ready[i];
      return ok;
   endfunction

   task automatic tick();
      bit f;
      @(posedge clk);
      if (reset) begin
         for (int i = 0; i < 4; i++) begin
            mv[i] = 1'b0;
            md[i] = 8'h00;
         end
         mcnt = 0;
      end else begin
         f = in_valid && m_ready();
         for (int i = 0; i < 4; i++) begin
            if (f && (in_bcast || in_sel == 2'(i))) begin
               mv[i] = 1'b1;
               md[i] = in_data;
            end else if (out_ready[i]) begin
               mv[i] = 1'b0;
            end
         end
         if (f) mcnt++;
      end
      #1;
   endtask

   task automatic idle_outs();
      for (int i = 0; i < 4; i++) out_ready[i] = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      in_valid = 1'b1;
      in_sel = 2'd0;
      in_bcast = 1'b0;
      in_data = 8'h77;
      idle_outs();
      #1;
      n_checks++;
      if (in_ready !== 1'b0) begin
         n_errors++;
         $display("FAIL rst_ready: got %b exp 0", in_ready);
      end
      tick();
      tick();
      reset = 1'b0;
      in_valid = 1'b0;
      #1;
      n_checks++;
      if (ov() !== 4'b0000) begin
         n_errors++;
         $display("FAIL rst_valid: got %b exp 0000", ov());
      end
      n_checks++;
      if (busy !== 1'b0 || xfer_cnt !== 16'd0) begin
         n_errors++;
         $display("FAIL rst_state: busy %b cnt %0d exp 0 0",
                  busy, xfer_cnt);
      end
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (out_data[i] !== 8'h00) begin
            n_errors++;
            $display("FAIL rst_data%0d: got %h exp 00", i, out_data[i]);
         end
      end
   endtask

   task automatic test_single_route();
      in_valid = 1'b1;
      in_sel = 2'd2;
      in_data = 8'hA5;
      #1;
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_errors++;
         $display("FAIL route_ready: got %b exp 1", in_ready);
      end
      tick();
      in_valid = 1'b0;
      #1;
      n_checks++;
      if (ov() !== 4'b0100) begin
         n_errors++;
         $display("FAIL route_valid: got %b exp 0100", ov());
      end
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (out_data[i] !== ((i == 2) ? 8'hA5 : 8'h00)) begin
            n_errors++;
            $display("FAIL route_data%0d: got %h", i, out_data[i]);
         end
      end
      n_checks++;
      if (busy !== 1'b1 || xfer_cnt !== 16'd1) begin
         n_errors++;
         $display("FAIL route_state: busy %b cnt %0d exp 1 1",
                  busy, xfer_cnt);
      end
   endtask

   task automatic test_backpressure();
      in_valid = 1'b1;
      in_sel = 2'd2;
      in_data = 8'h3C;
      #1;
      n_checks++;
      if (in_ready !== 1'b0) begin
         n_errors++;
         $display("FAIL bp_ready: got %b exp 0", in_ready);
      end
      tick();
      n_checks++;
      if (out_data[2] !== 8'hA5 || xfer_cnt !== 16'd1) begin
         n_errors++;
         $display("FAIL bp_hold: got %h cnt %0d exp a5 1",
                  out_data[2], xfer_cnt);
      end
      out_ready[2] = 1'b1;
      #1;
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_errors++;
         $display("FAIL bp_release: got %b exp 1", in_ready);
      end
      tick();
      in_valid = 1'b0;
      out_ready[2] = 1'b0;
      #1;
      n_checks++;
      if (out_data[2] !== 8'h3C || xfer_cnt !== 16'd2) begin
         n_errors++;
         $display("FAIL bp_reload: got %h cnt %0d exp 3c 2",
                  out_data[2], xfer_cnt);
      end
   endtask

   task automatic test_parallel();
      in_valid = 1'b1;
      in_sel = 2'd1;
      in_data = 8'h11;
      #1;
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_errors++;
         $display("FAIL par_ready: got %b exp 1", in_ready);
      end
      tick();
      in_valid = 1'b0;
      #1;
      n_checks++;
      if (ov() !== 4'b0110) begin
         n_errors++;
         $display("FAIL par_valid: got %b exp 0110", ov());
      end
      n_checks++;
      if (out_data[1] !== 8'h11 || out_data[2] !== 8'h3C) begin
         n_errors++;
         $display("FAIL par_data: got %h %h exp 11 3c",
                  out_data[1], out_data[2]);
      end
   endtask

   task automatic test_back_to_back();
      out_ready[0] = 1'b1;
      for (int k = 0; k < 8; k++) begin
         in_valid = 1'b1;
         in_sel = 2'd0;
         in_data = 8'(k);
         #1;
         n_checks++;
         if (in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL b2b_ready%0d: got %b exp 1", k, in_ready);
         end
         tick();
         n_checks++;
         if (out_valid[0] !== 1'b1 || out_data[0] !== 8'(k)) begin
            n_errors++;
            $display("FAIL b2b_data%0d: got %b/%h exp 1/%h",
                     k, out_valid[0], out_data[0], 8'(k));
         end
      end
      in_valid = 1'b0;
      n_checks++;
      if (xfer_cnt !== 16'd11) begin
         n_errors++;
         $display("FAIL b2b_cnt: got %0d exp 11", xfer_cnt);
      end
      tick();
      out_ready[0] = 1'b0;
      #1;
      n_checks++;
      if (out_valid[0] !== 1'b0 || out_data[0] !== 8'h00) begin
         n_errors++;
         $display("FAIL b2b_drain: got %b/%h exp 0/00",
                  out_valid[0], out_data[0]);
      end
   endtask

   task automatic test_broadcast();
      in_valid = 1'b1;
      in_sel = 2'd3;
      in_data = 8'h33;
      tick();
      out_ready[1] = 1'b1;
      out_ready[2] = 1'b1;
      in_bcast = 1'b1;
      in_sel = 2'd0;
      in_data = 8'hFF;
      #1;
      n_checks++;
      if (in_ready !== 1'b0) begin
         n_errors++;
         $display("FAIL bc_block: got %b exp 0", in_ready);
      end
      tick();
      n_checks++;
      if (ov() !== 4'b1000 || out_data[3] !== 8'h33) begin
         n_errors++;
         $display("FAIL bc_partial: got %b/%h exp 1000/33",
                  ov(), out_data[3]);
      end
      n_checks++;
      if (xfer_cnt !== 16'd12) begin
         n_errors++;
         $display("FAIL bc_cnt0: got %0d exp 12", xfer_cnt);
      end
      out_ready[3] = 1'b1;
      #1;
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_errors++;
         $display("FAIL bc_release: got %b exp 1", in_ready);
      end
      tick();
      in_valid = 1'b0;
      in_bcast = 1'b0;
      idle_outs();
      #1;
      n_checks++;
      if (ov() !== 4'b1111 || xfer_cnt !== 16'd13) begin
         n_errors++;
         $display("FAIL bc_all: got %b cnt %0d exp 1111 13",
                  ov(), xfer_cnt);
      end
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (out_data[i] !== 8'hFF) begin
            n_errors++;
            $display("FAIL bc_data%0d: got %h exp ff", i, out_data[i]);
         end
      end
   endtask

   task automatic test_reset_midstream();
      in_valid = 1'b1;
      in_sel = 2'd0;
      in_data = 8'h5A;
      out_ready[0] = 1'b1;
      reset = 1'b1;
      #1;
      n_checks++;
      if (in_ready !== 1'b0) begin
         n_errors++;
         $display("FAIL mid_ready: got %b exp 0", in_ready);
      end
      tick();
      reset = 1'b0;
      in_valid = 1'b0;
      out_ready[0] = 1'b0;
      #1;
      n_checks++;
      if (ov() !== 4'b0000 || busy !== 1'b0) begin
         n_errors++;
         $display("FAIL mid_clear: got %b busy %b exp 0000 0",
                  ov(), busy);
      end
      n_checks++;
      if (xfer_cnt !== 16'd0 || out_data[0] !== 8'h00) begin
         n_errors++;
         $display("FAIL mid_cnt: got %0d/%h exp 0/00",
                  xfer_cnt, out_data[0]);
      end
   endtask

   task automatic test_wrap();
      out_ready[0] = 1'b1;
      in_valid = 1'b1;
      in_sel = 2'd0;
      for (int k = 0; k < 17; k++) begin
         in_data = 8'($urandom);
         tick();
         if (k == 15) begin
            n_checks++;
            if (w_xfer !== 4'd0 || xfer_cnt !== 16'd16) begin
               n_errors++;
               $display("FAIL wrap16: got %0d/%0d exp 0/16",
                        w_xfer, xfer_cnt);
            end
         end
      end
      in_valid = 1'b0;
      n_checks++;
      if (w_xfer !== 4'd1 || xfer_cnt !== 16'd17) begin
         n_errors++;
         $display("FAIL wrap17: got %0d/%0d exp 1/17",
                  w_xfer, xfer_cnt);
      end
      tick();
      out_ready[0] = 1'b0;
   endtask

   task automatic test_random();
      bit fired;
      bit was_reset;
      fired = 1'b1;
      was_reset = 1'b0;
      for (int c = 0; c < 400; c++) begin
         if (was_reset || !in_valid || fired) begin
            in_valid = ($urandom_range(3) != 0);
            in_sel = 2'($urandom);
            in_bcast = ($urandom_range(7) == 0);
            in_data = 8'($urandom);
         end
         for (int i = 0; i < 4; i++) out_ready[i] = 1'($urandom);
         reset = ($urandom_range(63) == 0);
         #1;
         n_checks++;
         if (in_ready !== m_ready() || w_in_ready !== m_ready()) begin
            n_errors++;
            $display("FAIL rnd_ready c%0d: got %b/%b exp %b",
                     c, in_ready, w_in_ready, m_ready());
         end
         for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (out_valid[i] !== mv[i] ||
                out_data[i] !== (mv[i] ? md[i] : 8'h00) ||
                w_out_valid[i] !== mv[i] ||
                w_out_data[i] !== (mv[i] ? md[i] : 8'h00)) begin
               n_errors++;
               $display("FAIL rnd_ch%0d c%0d: got %b/%h exp %b/%h",
                        i, c, out_valid[i], out_data[i],
                        mv[i], mv[i] ? md[i] : 8'h00);
            end
         end
         n_checks++;
         if (busy !== (mv[0] | mv[1] | mv[2] | mv[3]) ||
             w_busy !== busy ||
             xfer_cnt !== 16'(mcnt) || w_xfer !== 4'(mcnt)) begin
            n_errors++;
            $display("FAIL rnd_state c%0d: busy %b cnt %0d/%0d exp %0d",
                     c, busy, xfer_cnt, w_xfer, mcnt);
         end
         fired = in_valid && m_ready();
         was_reset = reset;
         tick();
      end
      reset = 1'b0;
      in_valid = 1'b0;
      in_bcast = 1'b0;
      idle_outs();
   endtask

   initial begin
      test_reset();
      test_single_route();
      test_backpressure();
      test_parallel();
      test_back_to_back();
      test_broadcast();
      test_reset_midstream();
      test_wrap();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/stream_demux.md
Name: stream_demux

Overview:
- Registered, flow-controlled successor of the combinational one-hot demux.
- Routes one valid/ready input stream to one of 2**CTRL output channels selected per transfer, or to all channels at once (broadcast).
- Each output channel has a one-entry output register, so there is one cycle of latency and full throughput per channel.
- Used between issue/dispatch logic and per-unit request queues.

Parameters:
- CTRL, 2, select width; channel count N = 2**CTRL.
- DATA_WIDTH, 1, payload width in bits.
- CNT_WIDTH, 16, width of the wrapping transfer counter.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  input transfer request.
- in_ready  output  1  input can be accepted this cycle.
- in_data  input  DATA_WIDTH  input payload.
- in_sel  input  CTRL  target channel index; ignored when in_bcast=1.
- in_bcast  input  1  deliver the payload to all N channels.
- out_valid  output  1 x N (unpacked [N])  channel i holds data.
- out_ready  input  1 x N (unpacked [N])  channel i consumer accepts this cycle.
- out_data  output  DATA_WIDTH x N (unpacked [N])  channel i payload.
- busy  output  1  OR of all out_valid.
- xfer_cnt  output  CNT_WIDTH  count of accepted input transfers.

Behaviour:
- State per channel i: valid_q[i], data_q[i]. Global state: xfer_cnt register.
- Reset (reset=1 at a clock edge): all valid_q=0, all data_q=0, xfer_cnt=0.
- While reset is high, in_ready=0 combinationally. No transfer is accepted in the cycle reset is asserted, including a reset asserted mid-stream. Held data is discarded.
- Output mapping:
  - out_valid[i]=valid_q[i].
  - out_data[i]=data_q[i] when valid_q[i]=1, else all zeros. Never expose stale data.
- Channel acceptance: can_acc[i] = !valid_q[i] || out_ready[i]. A full channel being drained this cycle can be reloaded in the same cycle.
- Input ready:
  - in_bcast=0: in_ready = can_acc[in_sel].
  - in_bcast=1: in_ready = AND of can_acc over all N channels. Broadcast is all-or-nothing; there is never a partial broadcast.
  - in_ready depends combinationally on out_ready and on in_sel/in_bcast. No combinational path exists from in_valid to in_ready.
- Fire: fire = in_valid && in_ready && !reset.
- Channel update, per channel i, per cycle:
  - If fire and (in_bcast or in_sel==i): valid_q[i]<=1, data_q[i]<=in_data.
  - Else if out_ready[i]: valid_q[i]<=0; data_q[i] is held, but is not visible because the output is zeroed.
  - Else: hold.
- Latency: an input fired in cycle t appears on out_valid/out_data in cycle t+1.
- Throughput: one transfer per cycle, sustained, if the target out_ready stays high.
- Independence: non-targeted channels drain independently in the same cycle as a fire to another channel.
- out_ready[i] asserted while valid_q[i]=0 has no effect.
- xfer_cnt:
  - Increments by 1 on every fire; a broadcast counts as 1.
  - Wraps modulo 2**CNT_WIDTH with no saturation.
- busy = |valid_q, registered-derived (no input dependence).
- Source protocol: in_data, in_sel and in_bcast stay stable while in_valid=1 and in_ready=0. A source must not drop in_valid before the transfer fires. The bench asserts this; the DUT does not check it.
- Consumer protocol: out_valid[i] stays high and out_data[i] stays stable until out_ready[i]=1 (hold under backpressure).
- in_sel is always in range because N = 2**CTRL.

Test Plan:
- Single route (CTRL=2, DATA_WIDTH=8): reset 2 cycles, then in_valid=1, in_sel=2, in_data=0xA5, all out_ready=0 -> in_ready=1. Next cycle out_valid=0100, out_data[2]=0xA5, other outputs 0x00, busy=1, xfer_cnt=1.
- Backpressure: with channel 2 full and out_ready[2]=0, send in_sel=2, 0x3C -> in_ready=0 and out_data[2] holds 0xA5. Raise out_ready[2] -> same-cycle fire; next cycle out_data[2]=0x3C, xfer_cnt=2.
- Parallel: while channel 2 is stalled, send in_sel=1, 0x11 -> accepted. Next cycle out_valid=0110 and channel 2 is unaffected.
- Streaming: out_ready[0]=1, 8 back-to-back fires to channel 0 with data 0..7 -> in_ready stays 1, out_data[0] shows 0..7 on consecutive cycles, xfer_cnt increases by 8.
- Broadcast: channel 3 full with out_ready[3]=0, in_bcast=1, in_data=0xFF -> in_ready=0 and no channel is loaded. Release out_ready[3] -> all four channels show 0xFF next cycle, xfer_cnt increases by 1.
- Reset and wrap:
  - Assert reset with channels full and in_valid=1 -> in_ready=0 that cycle; next cycle out_valid=0000, busy=0, xfer_cnt=0.
  - Separately, with CNT_WIDTH=4, 17 fires -> xfer_cnt=1.
